// File: rtl/screen_seq_ctrl.sv
// Screen sequencer for the snake game: START -> PLAY -> OVER -> START, switching only at frame
// boundaries, plus the shared start/end image ROM address counter and snake-logic gating.
module screen_seq_ctrl #(
  parameter int unsigned IMG_W            = 200,
  parameter int unsigned IMG_H            = 200,
  parameter int unsigned ADDR_W           = 17,
  parameter int unsigned OVER_HOLD_FRAMES = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_vs,
  input  logic              key_start,
  input  logic              snake_dead,
  input  logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [1:0]        screen_sel,
  output logic              game_en,
  output logic              game_rst
);

  localparam int unsigned ImgSize = IMG_W * IMG_H;
  localparam int unsigned HoldW   = $clog2(OVER_HOLD_FRAMES + 1);

  localparam logic [ADDR_W-1:0] StartBase = '0;
  localparam logic [ADDR_W-1:0] StartLast = ADDR_W'(ImgSize - 1);
  localparam logic [ADDR_W-1:0] OverBase  = ADDR_W'(ImgSize);
  localparam logic [ADDR_W-1:0] OverLast  = ADDR_W'(2 * ImgSize - 1);
  localparam logic [HoldW-1:0]  HoldMax   = HoldW'(OVER_HOLD_FRAMES);

  // State encoding doubles as the VGA source select.
  localparam logic [1:0] StStart = 2'd0;
  localparam logic [1:0] StPlay  = 2'd1;
  localparam logic [1:0] StOver  = 2'd2;

  logic              vs_q;
  logic [1:0]        state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              start_req_q, start_req_d;
  logic              dead_req_q, dead_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;

  logic              frame_tick;
  logic              start_ok, dead_ok;
  logic              start_pend, dead_pend;
  logic [ADDR_W-1:0] cur_base, cur_last, next_base;

  // Requests arriving in the tick cycle are folded in so that tick consumes them.
  always_comb begin
    frame_tick = vga_vs & ~vs_q;
    start_ok   = key_start & ((state_q == StStart) | ((state_q == StOver) & (hold_q == HoldMax)));
    dead_ok    = snake_dead & (state_q == StPlay);
    start_pend = start_req_q | start_ok;
    dead_pend  = dead_req_q | dead_ok;
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    start_req_d = frame_tick ? 1'b0 : start_pend;
    dead_req_d  = frame_tick ? 1'b0 : dead_pend;
    if (frame_tick) begin
      case (state_q)
        StStart: begin
          if (start_pend) state_d = StPlay;
        end
        StPlay: begin
          if (dead_pend) begin
            state_d = StOver;
            hold_d  = '0;
          end
        end
        StOver: begin
          if (start_pend) begin
            state_d = StStart;
            hold_d  = '0;
          end else if (hold_q != HoldMax) begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: begin
          state_d = StStart;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    cur_base  = (state_q == StOver) ? OverBase : StartBase;
    cur_last  = (state_q == StOver) ? OverLast : StartLast;
    next_base = (state_d == StOver) ? OverBase : StartBase;
    addr_d    = addr_q;
    if (frame_tick) begin
      addr_d = next_base;
    end else if (state_q == StPlay) begin
      addr_d = '0;
    end else if (rom_rd_en) begin
      addr_d = (addr_q == cur_last) ? cur_base : addr_q + 1'b1;
    end
    en_d = (state_d == StPlay);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q        <= 1'b1;
      state_q     <= StStart;
      hold_q      <= '0;
      start_req_q <= 1'b0;
      dead_req_q  <= 1'b0;
      addr_q      <= '0;
      en_q        <= 1'b0;
    end else begin
      vs_q        <= vga_vs;
      state_q     <= state_d;
      hold_q      <= hold_d;
      start_req_q <= start_req_d;
      dead_req_q  <= dead_req_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
    end
  end

  // game_rst is combinational so it lands in the transitioning tick cycle, ahead of game_en.
  assign game_rst   = frame_tick & (state_q == StStart) & start_pend;
  assign rom_addr   = addr_q;
  assign screen_sel = state_q;
  assign game_en    = en_q;

endmodule
